// File: rtl/io_pkg.sv
// Shared constants and types for the CPU I/O responder.
package io_pkg;

    localparam int IO_DATA_W = 16;
    localparam int IO_PORT_W = 2;
    localparam int IO_DEPTH  = 4;

    localparam logic [IO_PORT_W-1:0] STATUS_ADDR = '1;
    localparam int STATUS_OVF_BIT = 15;

    typedef struct packed {
        logic [IO_PORT_W-1:0] port;
        logic [IO_DATA_W-1:0] data;
    } io_entry_t;

    // count needs one extra bit so that a full FIFO is distinguishable from empty
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous write FIFO with count-based full/empty; pointers wrap modulo DEPTH.
module io_fifo
    import io_pkg::*;
#(
    parameter int W     = IO_PORT_W + IO_DATA_W,
    parameter int DEPTH = IO_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            mem    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/io_responder.sv
// CPU port I/O responder: queued port writes to a device, latched input ports for reads.
// Define IO_STATUS_PORT_EN to map the status word (ovf, count) onto the top port address.
module io_responder
    import io_pkg::*;
#(
    parameter int DATA_W = IO_DATA_W,
    parameter int DEPTH  = IO_DEPTH,
    parameter int PORT_W = IO_PORT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [PORT_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic [DATA_W-1:0] cpu_rd,
    output logic              cpu_stall,
    output logic              dev_valid,
    input  logic              dev_ready,
    output logic [PORT_W-1:0] dev_port,
    output logic [DATA_W-1:0] dev_data,
    input  logic              in_valid,
    input  logic [PORT_W-1:0] in_port,
    input  logic [DATA_W-1:0] in_data
);

    localparam int NPORT = 1 << PORT_W;
    localparam int CW    = cnt_w(DEPTH);
    localparam logic [PORT_W-1:0] STAT_A = PORT_W'(NPORT - 1);
`ifdef IO_STATUS_PORT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic                           full;
    logic                           empty;
    logic [CW-1:0]                  count;
    logic [PORT_W+DATA_W-1:0]       head;
    logic                           ovf;
    logic                           ovf_set;
    logic                           ovf_clr;
    logic                           stat_sel;
    logic [DATA_W-1:0]              status;
    logic [NPORT-1:0][DATA_W-1:0]   lat;

    io_fifo #(
        .W     (PORT_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cpu_we),
        .pop   (dev_ready),
        .wdata ({cpu_addr, cpu_wd}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign dev_valid             = !empty;
    assign {dev_port, dev_data}  = head;
    // stall looks only at full so dev_ready never reaches the CPU combinationally
    assign cpu_stall             = cpu_we && full;

    assign stat_sel = STAT_EN && (cpu_addr == STAT_A);
    assign ovf_set  = cpu_we && full;
    assign ovf_clr  = stat_sel && cpu_re;

    // a clearing read that coincides with a new overflow leaves ovf set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ovf <= 1'b0;
        else        ovf <= ovf_set || (ovf && !ovf_clr);
    end

    always_comb begin
        status                 = '0;
        status[STATUS_OVF_BIT] = ovf;
        status[CW-1:0]         = count;
    end

    for (genvar g = 0; g < NPORT; g++) begin : g_lat
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                lat[g] <= '0;
            else if (in_valid && in_port == PORT_W'(g) && !(STAT_EN && g == NPORT - 1))
                lat[g] <= in_data;
        end
    end

    assign cpu_rd = stat_sel ? status : lat[cpu_addr];

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: vector table, corner-case sequences, random traffic vs queue model.
module tb_io_responder;
    import io_pkg::*;

`ifdef IO_STATUS_PORT_EN
    localparam bit S = 1'b1;
`else
    localparam bit S = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_we = 1'b0, cpu_re = 1'b0;
    logic [1:0]  cpu_addr = '0;
    logic [15:0] cpu_wd = '0;
    logic [15:0] cpu_rd;
    logic        cpu_stall;
    logic        dev_valid;
    logic        dev_ready = 1'b0;
    logic [1:0]  dev_port;
    logic [15:0] dev_data;
    logic        in_valid = 1'b0;
    logic [1:0]  in_port = '0;
    logic [15:0] in_data = '0;

    io_responder dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_addr  (cpu_addr),
        .cpu_wd    (cpu_wd),
        .cpu_rd    (cpu_rd),
        .cpu_stall (cpu_stall),
        .dev_valid (dev_valid),
        .dev_ready (dev_ready),
        .dev_port  (dev_port),
        .dev_data  (dev_data),
        .in_valid  (in_valid),
        .in_port   (in_port),
        .in_data   (in_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // reference model: plain queue of entries, latch array, sticky flag
    io_entry_t   q[$];
    logic [15:0] lat [4];
    logic        movf;

    task automatic m_reset();
        q.delete();
        for (int i = 0; i < 4; i++) lat[i] = '0;
        movf = 1'b0;
    endtask

    function automatic logic [15:0] m_rd(input logic [1:0] a);
        if (S && a == STATUS_ADDR)
            return (movf ? 16'h8000 : 16'h0000) | 16'(q.size());
        return lat[a];
    endfunction

    logic        s_valid, s_stall;
    logic [1:0]  s_port;
    logic [15:0] s_data, s_rd;

    // one CPU cycle: drive, compare against the model, clock, advance the model
    task automatic cyc(input int we, input int re, input int addr, input int wd,
                       input int rdy, input int inv, input int ip, input int id);
        bit full, popv, pushv;
        cpu_we = 1'(we); cpu_re = 1'(re); cpu_addr = 2'(addr); cpu_wd = 16'(wd);
        dev_ready = 1'(rdy); in_valid = 1'(inv); in_port = 2'(ip); in_data = 16'(id);
        #1;
        s_valid = dev_valid; s_port = dev_port; s_data = dev_data;
        s_stall = cpu_stall; s_rd = cpu_rd;
        full = (q.size() == IO_DEPTH);
        chk("m.dev_valid", s_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("m.dev_port", s_port, q[0].port);
            chk("m.dev_data", s_data, q[0].data);
        end
        chk("m.cpu_stall", s_stall, cpu_we && full);
        chk("m.cpu_rd", s_rd, m_rd(cpu_addr));
        popv  = (q.size() != 0) && dev_ready;
        pushv = cpu_we && !full;
        if (popv) void'(q.pop_front());
        if (pushv) q.push_back('{port: cpu_addr, data: cpu_wd});
        movf = (cpu_we && full) || (movf && !(S && cpu_re && cpu_addr == STATUS_ADDR));
        if (in_valid && !(S && in_port == STATUS_ADDR)) lat[in_port] = in_data;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int we, re, addr, wd, rdy, inv, ip, id;
        int ev, ep, ed, es, erd;
    } row_t;
    row_t tbl[$];

    task automatic add(input int we, input int re, input int addr, input int wd,
                       input int rdy, input int inv, input int ip, input int id,
                       input int ev, input int ep, input int ed, input int es, input int erd);
        row_t r;
        r = '{we, re, addr, wd, rdy, inv, ip, id, ev, ep, ed, es, erd};
        tbl.push_back(r);
    endtask

    initial begin
        //   we re a  wd      rdy iv ip id        ev ep ed      es erd
        add(0, 0, 0, 0,      0, 0, 0, 0,       0, 0, 0,      0, 0);
        add(0, 0, 1, 0,      0, 0, 0, 0,       0, 0, 0,      0, 0);
        add(0, 0, 2, 0,      0, 0, 0, 0,       0, 0, 0,      0, 0);
        add(0, 0, 3, 0,      0, 0, 0, 0,       0, 0, 0,      0, 0);
        add(1, 0, 1, 'hAB,   0, 0, 0, 0,       0, 0, 0,      0, 0);
        add(0, 0, 0, 0,      0, 0, 0, 0,       1, 1, 'hAB,   0, 0);
        add(0, 0, 0, 0,      0, 0, 0, 0,       1, 1, 'hAB,   0, 0);
        add(0, 0, 0, 0,      1, 0, 0, 0,       1, 1, 'hAB,   0, 0);
        add(0, 0, 0, 0,      0, 0, 0, 0,       0, 0, 0,      0, 0);
        add(1, 0, 0, 1,      0, 0, 0, 0,       0, 0, 0,      0, 0);
        add(1, 0, 0, 2,      0, 0, 0, 0,       1, 0, 1,      0, 0);
        add(1, 0, 0, 3,      0, 0, 0, 0,       1, 0, 1,      0, 0);
        add(1, 0, 0, 4,      0, 0, 0, 0,       1, 0, 1,      0, 0);
        add(1, 0, 0, 5,      0, 0, 0, 0,       1, 0, 1,      1, 0);
        add(0, 1, 3, 0,      0, 0, 0, 0,       1, 0, 1,      0, S ? 'h8004 : 0);
        add(0, 1, 3, 0,      0, 0, 0, 0,       1, 0, 1,      0, S ? 'h0004 : 0);
        add(1, 0, 0, 6,      1, 0, 0, 0,       1, 0, 1,      1, 0);
        add(0, 1, 3, 0,      0, 0, 0, 0,       1, 0, 2,      0, S ? 'h8003 : 0);
        add(0, 1, 3, 0,      0, 0, 0, 0,       1, 0, 2,      0, S ? 'h0003 : 0);
        add(0, 0, 0, 0,      1, 0, 0, 0,       1, 0, 2,      0, 0);
        add(0, 0, 0, 0,      1, 0, 0, 0,       1, 0, 3,      0, 0);
        add(0, 0, 0, 0,      1, 0, 0, 0,       1, 0, 4,      0, 0);
        add(0, 0, 0, 0,      0, 0, 0, 0,       0, 0, 0,      0, 0);
        add(0, 0, 2, 0,      0, 1, 2, 'hBEEF,  0, 0, 0,      0, 0);
        add(0, 0, 2, 0,      0, 0, 0, 0,       0, 0, 0,      0, 'hBEEF);
        add(0, 0, 3, 0,      0, 1, 3, 'h1234,  0, 0, 0,      0, 0);
        add(0, 0, 3, 0,      0, 0, 0, 0,       0, 0, 0,      0, S ? 0 : 'h1234);

        m_reset();
        cpu_we = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.dev_valid", dev_valid, 0);
        chk("rst.cpu_stall", cpu_stall, 0);
        cpu_we = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            row_t r;
            r = tbl[i];
            cyc(r.we, r.re, r.addr, r.wd, r.rdy, r.inv, r.ip, r.id);
            chk($sformatf("row%0d.valid", i), s_valid, r.ev);
            if (r.ev != 0) begin
                chk($sformatf("row%0d.port", i), s_port, r.ep);
                chk($sformatf("row%0d.data", i), s_data, r.ed);
            end
            chk($sformatf("row%0d.stall", i), s_stall, r.es);
            chk($sformatf("row%0d.rd", i), s_rd, r.erd);
        end

        // streaming with device always ready, eight writes wrap the pointers twice
        for (int k = 0; k <= 8; k++) begin
            cyc(k < 8, 0, 1, 'h10 + k, 1, 0, 0, 0);
            chk($sformatf("stream%0d.stall", k), s_stall, 0);
            if (k >= 1) begin
                chk($sformatf("stream%0d.valid", k), s_valid, 1);
                chk($sformatf("stream%0d.data", k), s_data, 'h10 + k - 1);
            end
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("stream.drained", s_valid, 0);

        // overflow and clearing read in the same cycle: the set wins
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 'h20 + k, 0, 0, 0, 0);
        cyc(1, 1, 3, 'h99, 0, 0, 0, 0);
        chk("ovfclr.stall", s_stall, 1);
        chk("ovfclr.rd0", s_rd, S ? 'h0004 : 'h1234);
        cyc(0, 1, 3, 0, 0, 0, 0, 0);
        chk("ovfclr.rd1", s_rd, S ? 'h8004 : 'h1234);

        // reset mid-operation with three entries queued and ovf set
        cyc(1, 0, 0, 'h55, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cpu_we = 1'b1; cpu_addr = 2'd3; dev_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst.dev_valid", dev_valid, 0);
        chk("midrst.cpu_stall", cpu_stall, 0);
        m_reset();
        @(posedge clk);
        #1;
        chk("midrst.hold_valid", dev_valid, 0);
        cpu_we = 1'b0;
        reset = 1'b1;
        cyc(0, 1, 3, 0, 0, 0, 0, 0);
        chk("midrst.status", s_rd, 0);
        cyc(1, 0, 1, 'h77, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("midrst.push_valid", s_valid, 1);
        chk("midrst.push_data", s_data, 'h77);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);

        // random traffic against the model
        for (int n = 0; n < 800; n++) begin
            cyc($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 25,
                $urandom_range(0, 3), $urandom_range(0, 16'hFFFF),
                $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 30,
                $urandom_range(0, 3), $urandom_range(0, 16'hFFFF));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
